// File: rtl/ttc_irq_ctrl10.sv
// ttc_irq_ctrl10: interrupt collector for the triple timer counter.
// Latches edge/level events per TTC source, masks them, counts rising edges
// per source, and drives one prioritised, hold-off-gated interrupt line.
// Ports:
//   pclk10, n_p_reset10      clock, synchronous active-low reset
//   psel10..pwdata10         APB slave request (no wait states)
//   prdata10                 registered APB read data, 0 when idle
//   ttc_int10                TTC interrupt sources (bit 0 = source 1)
//   irq_out10, irq_id10      registered interrupt line and active source id
module ttc_irq_ctrl10 #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               pclk10,
  input  logic               n_p_reset10,
  input  logic               psel10,
  input  logic               penable10,
  input  logic               pwrite10,
  input  logic [7:0]         paddr10,
  input  logic [31:0]        pwdata10,
  input  logic [NUM_SRC-1:0] ttc_int10,
  output logic [31:0]        prdata10,
  output logic               irq_out10,
  output logic [1:0]         irq_id10
);

  // Word indices of the register map
  localparam logic [5:0] A_RAW     = 6'h00;
  localparam logic [5:0] A_PEND    = 6'h01;
  localparam logic [5:0] A_MASK    = 6'h02;
  localparam logic [5:0] A_MODE    = 6'h03;
  localparam logic [5:0] A_VECTOR  = 6'h04;
  localparam logic [5:0] A_HOLDOFF = 6'h05;
  localparam logic [5:0] A_COUNT   = 6'h06;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mode;
  logic [CNT_W-1:0]   holdoff;
  logic [CNT_W-1:0]   hcnt;
  logic               irq_d;
  logic [CNT_W-1:0]   cnt [NUM_SRC];

  logic [5:0]         widx;
  logic               wr_en;
  logic               rd_setup;
  logic               rd_access;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] set;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] active;
  logic [1:0]         id_nxt;
  logic [CNT_W-1:0]   hcnt_nxt;
  logic               irq_nxt;
  logic               cnt_clr;
  logic [CNT_W-1:0]   cnt_nxt [NUM_SRC];
  logic [31:0]        rdata;

  logic unused;
  assign unused = ^{paddr10[1:0], pwdata10[31:CNT_W]};

  assign widx      = paddr10[7:2];
  assign wr_en     = psel10 & penable10 & pwrite10;
  assign rd_setup  = psel10 & ~penable10 & ~pwrite10;
  assign rd_access = psel10 & penable10 & ~pwrite10;

  // Event detection and pending update; a set beats a same-cycle W1C clear
  always_comb begin
    rise     = ttc_int10 & ~src_d;
    set      = (mode & rise) | (~mode & ttc_int10);
    clr      = (wr_en && widx == A_PEND) ? pwdata10[NUM_SRC-1:0] : '0;
    pend_nxt = (pend & ~clr) | set;
    active   = pend & mask;
  end

  // Priority encode: lowest-numbered source wins
  always_comb begin
    id_nxt = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) id_nxt = 2'(i + 1);
    end
  end

  // Hold-off reloads one cycle after the line falls; the line is gated on the
  // counter's next value so it stays low through the reload cycle itself
  always_comb begin
    hcnt_nxt = hcnt;
    if (irq_d && !irq_out10) hcnt_nxt = holdoff;
    else if (hcnt != '0)     hcnt_nxt = hcnt - CNT_W'(1);
    irq_nxt = (|active) && (hcnt_nxt == '0);
  end

  // Saturating per-source edge counters; an edge coinciding with a clear leaves 1
  always_comb begin
    cnt_clr = wr_en && (widx == A_COUNT);
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_nxt[i] = cnt[i];
      if (cnt_clr)                          cnt_nxt[i] = rise[i] ? CNT_W'(1) : '0;
      else if (rise[i] && cnt[i] != CNT_MAX) cnt_nxt[i] = cnt[i] + CNT_W'(1);
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (widx)
      A_RAW:     rdata[NUM_SRC-1:0] = ttc_int10;
      A_PEND:    rdata[NUM_SRC-1:0] = pend;
      A_MASK:    rdata[NUM_SRC-1:0] = mask;
      A_MODE:    rdata[NUM_SRC-1:0] = mode;
      A_VECTOR:  rdata = {irq_out10, 29'd0, irq_id10};
      A_HOLDOFF: rdata[CNT_W-1:0] = holdoff;
      A_COUNT: begin
        for (int i = 0; i < NUM_SRC; i++) rdata[i*CNT_W +: CNT_W] = cnt[i];
      end
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge pclk10) begin
    if (!n_p_reset10) begin
      src_d     <= '0;
      pend      <= '0;
      mask      <= '0;
      mode      <= '1;
      holdoff   <= '0;
      hcnt      <= '0;
      irq_d     <= 1'b0;
      irq_out10 <= 1'b0;
      irq_id10  <= 2'd0;
      prdata10  <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else begin
      src_d     <= ttc_int10;
      pend      <= pend_nxt;
      hcnt      <= hcnt_nxt;
      irq_d     <= irq_out10;
      irq_out10 <= irq_nxt;
      irq_id10  <= id_nxt;
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= cnt_nxt[i];

      if (wr_en) begin
        case (widx)
          A_MASK:    mask    <= pwdata10[NUM_SRC-1:0];
          A_MODE:    mode    <= pwdata10[NUM_SRC-1:0];
          A_HOLDOFF: holdoff <= pwdata10[CNT_W-1:0];
          default:   ;
        endcase
      end

      // Capture in setup, hold through access, zero otherwise
      if (rd_setup)        prdata10 <= rdata;
      else if (!rd_access) prdata10 <= '0;
    end
  end

endmodule
